lms_adapt_ctrl: RTL and testbench

Sequencing controller for the 16-tap LMS adaptive FIR. Gates the filter's sample clock-enable and adaptation, and flushes the delay line after start. Schedules the step-size shift (acquire vs. track) from a windowed average of |error|. Supports operator freeze and divergence fallback. Sits between the sample source and the filter's `mu_in` and enable inputs.

---
 rtl/lms_adapt_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_lms_adapt_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lms_adapt_ctrl
// Function : Sequencing controller for a 16-tap LMS adaptive FIR. Gates the
//            filter clock-enable, flushes the delay line after start, and
//            schedules the step-size shift (acquire vs. track) from a
//            windowed average of |error|. Handles freeze and divergence.
// Revision : 1.0 - initial release
// ============================================================================
module lms_adapt_ctrl #(
  parameter int         L        = 16,
  parameter int         EW       = 31,
  parameter int         WIN_LOG2 = 4,
  parameter int         HOLD     = 3,
  parameter logic [7:0] MU_SAFE  = 8'd31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              freeze,
  input  logic              sample_valid,
  input  logic              e_valid,
  input  logic [EW-1:0]     e_in,
  input  logic [7:0]        mu_acq,
  input  logic [7:0]        mu_trk,
  input  logic [EW-2:0]     err_thresh,
  output logic              fir_ce,
  output logic              adapt_en,
  output logic [7:0]        mu_out,
  output logic              converged,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [EW-2:0]     err_avg
);

  localparam int AW = EW - 1 + WIN_LOG2;   // accumulator cannot overflow
  localparam int FW = $clog2(L + 1);
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_flush  = 3'd1;
  localparam logic [2:0] c_st_acq    = 3'd2;
  localparam logic [2:0] c_st_track  = 3'd3;
  localparam logic [2:0] c_st_freeze = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [2:0]      saved_q, saved_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      mu_q, mu_d;
  logic            adapt_q, adapt_d;
  logic            conv_q, conv_d;
  logic            busy_q, busy_d;
  logic [EW-2:0]   err_avg_q, err_avg_d;

  logic [EW-2:0]   w_abs;
  logic [AW-1:0]   w_sum;
  logic [EW-2:0]   w_avg;
  logic [EW-2:0]   w_thr4;
  logic [HW-1:0]   w_hold_inc;
  logic            w_win_end;

  // Saturating |e|, window sum/average and the saturated divergence threshold
  always_comb begin
    w_abs = e_in[EW-2:0];
    if (e_in[EW-1]) begin
      if (e_in[EW-2:0] == '0) w_abs = '1;          // most-negative value
      else                    w_abs = (~e_in[EW-2:0]) + (EW-1)'(1);
    end
    w_sum      = acc_q + AW'(w_abs);
    w_avg      = w_sum[AW-1:WIN_LOG2];
    w_thr4     = (err_thresh[EW-2:EW-3] != 2'b00) ? '1 : {err_thresh[EW-4:0], 2'b00};
    w_hold_inc = hold_cnt_q + HW'(1);
    w_win_end  = e_valid && (win_cnt_q == '1);
  end

  // Next-state and registered-output logic; stop overrides everything
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    flush_cnt_d = flush_cnt_q;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    mu_d        = mu_q;
    adapt_d     = adapt_q;
    conv_d      = conv_q;
    busy_d      = busy_q;
    err_avg_d   = err_avg_q;

    if (stop) begin
      state_d     = c_st_idle;
      saved_d     = c_st_idle;
      flush_cnt_d = '0;
      acc_d       = '0;
      win_cnt_d   = '0;
      hold_cnt_d  = '0;
      mu_d        = MU_SAFE;
      adapt_d     = 1'b0;
      conv_d      = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (start) begin
            state_d     = c_st_flush;
            busy_d      = 1'b1;
            flush_cnt_d = '0;
            acc_d       = '0;
            win_cnt_d   = '0;
            hold_cnt_d  = '0;
          end
        end
        c_st_flush: begin
          if (sample_valid) begin
            if (flush_cnt_q == FW'(L - 1)) begin
              state_d = c_st_acq;
              mu_d    = mu_acq;
              adapt_d = 1'b1;
            end else begin
              flush_cnt_d = flush_cnt_q + FW'(1);
            end
          end
        end
        c_st_acq, c_st_track: begin
          if (freeze) begin
            // Partial window (even one ending this cycle) is discarded
            saved_d   = state_q;
            state_d   = c_st_freeze;
            acc_d     = '0;
            win_cnt_d = '0;
            adapt_d   = 1'b0;
            mu_d      = MU_SAFE;
          end else if (w_win_end) begin
            acc_d     = '0;
            win_cnt_d = '0;
            err_avg_d = w_avg;
            if (state_q == c_st_acq) begin
              if (w_avg < err_thresh) begin
                if (w_hold_inc == HW'(HOLD)) begin
                  state_d    = c_st_track;
                  mu_d       = mu_trk;
                  conv_d     = 1'b1;
                  hold_cnt_d = '0;
                end else begin
                  hold_cnt_d = w_hold_inc;
                end
              end else begin
                hold_cnt_d = '0;
              end
            end else if (w_avg >= w_thr4) begin
              state_d    = c_st_acq;
              mu_d       = mu_acq;
              conv_d     = 1'b0;
              hold_cnt_d = '0;
            end
          end else if (e_valid) begin
            acc_d     = w_sum;
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
          end
        end
        c_st_freeze: begin
          acc_d     = '0;
          win_cnt_d = '0;
          if (!freeze) begin
            state_d = saved_q;
            adapt_d = 1'b1;
            mu_d    = (saved_q == c_st_acq) ? mu_acq : mu_trk;
          end
        end
        default: begin
          state_d = c_st_idle;
          mu_d    = MU_SAFE;
          adapt_d = 1'b0;
          conv_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_st_idle;
      saved_q     <= c_st_idle;
      flush_cnt_q <= '0;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      mu_q        <= MU_SAFE;
      adapt_q     <= 1'b0;
      conv_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_avg_q   <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mu_q        <= mu_d;
      adapt_q     <= adapt_d;
      conv_q      <= conv_d;
      busy_q      <= busy_d;
      err_avg_q   <= err_avg_d;
    end
  end

  assign fir_ce    = sample_valid & (state_q != c_st_idle);
  assign adapt_en  = adapt_q;
  assign mu_out    = mu_q;
  assign converged = conv_q;
  assign busy      = busy_q;
  assign state_o   = state_q;
  assign err_avg   = err_avg_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_adapt_ctrl
// Function : Directed self-checking bench for lms_adapt_ctrl with a queue of
//            expected window averages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms_adapt_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, freeze, sample_valid, e_valid;
  logic [30:0] e_in;
  logic [7:0]  mu_acq, mu_trk;
  logic [29:0] err_thresh;
  logic        fir_ce, adapt_en, converged, busy;
  logic [7:0]  mu_out;
  logic [2:0]  state_o;
  logic [29:0] err_avg;

  int n_cmp = 0;
  int n_mis = 0;
  logic [29:0] exp_q[$];

  lms_adapt_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .freeze(freeze),
    .sample_valid(sample_valid), .e_valid(e_valid), .e_in(e_in),
    .mu_acq(mu_acq), .mu_trk(mu_trk), .err_thresh(err_thresh),
    .fir_ce(fir_ce), .adapt_en(adapt_en), .mu_out(mu_out),
    .converged(converged), .busy(busy), .state_o(state_o), .err_avg(err_avg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference saturating magnitude of a 31-bit signed error
  function automatic longint mag(input int v);
    longint m;
    m = (v < 0) ? -longint'(v) : longint'(v);
    if (m > 64'd1073741823) m = 64'd1073741823;
    return m;
  endfunction

  // Drive one full window of alternating a/b errors; push the expected average
  task automatic drive_window(input int a, input int b);
    longint sum;
    int v;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      v      = (i % 2 == 0) ? a : b;
      e_in   = v[30:0];
      e_valid = 1'b1;
      sum    = sum + mag(v);
      if (i == 15) exp_q.push_back(30'(sum >> 4));
      tick();
    end
    e_valid = 1'b0;
  endtask

  task automatic pop_avg(input string tag);
    logic [29:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(err_avg), 32'(e));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_adapt"}, 32'(adapt_en), 0);
    check({tag, "_mu"},    32'(mu_out), 31);
    check({tag, "_conv"},  32'(converged), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_avg"},   32'(err_avg), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; freeze = 1'b0;
    sample_valid = 1'b0; e_valid = 1'b0; e_in = '0;
    mu_acq = 8'd5; mu_trk = 8'd9; err_thresh = 30'd100;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("rst");
    sample_valid = 1'b1; #1;
    check("fir_ce_idle", 32'(fir_ce), 0);
    sample_valid = 1'b0;

    // Start and flush: 16 samples, one idle cycle apart
    start = 1'b1; tick(); start = 1'b0;
    check("start_state", 32'(state_o), 1);
    check("start_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1; #1;
      check("fir_ce_hi", 32'(fir_ce), 1);
      tick();
      sample_valid = 1'b0; #1;
      check("fir_ce_lo", 32'(fir_ce), 0);
      check("flush_state", 32'(state_o), (i < 15) ? 1 : 2);
      tick();
    end
    check("acq_adapt", 32'(adapt_en), 1);
    check("acq_mu", 32'(mu_out), 5);

    // Three converged windows of +/-50 -> TRACK on the third
    for (int w = 0; w < 3; w++) begin
      drive_window(50, -50);
      pop_avg("avg_pm50");
      check("conv_state", 32'(state_o), (w < 2) ? 2 : 3);
    end
    check("trk_mu", 32'(mu_out), 9);
    check("trk_conv", 32'(converged), 1);

    // Just under the divergence threshold stays in TRACK
    drive_window(399, 399);
    pop_avg("avg_399");
    check("stay_trk", 32'(state_o), 3);

    // Partial window, then freeze for 10 cycles
    e_in = '0; e_valid = 1'b1;
    repeat (5) tick();
    e_valid = 1'b0; freeze = 1'b1; tick();
    check("frz_state", 32'(state_o), 4);
    check("frz_adapt", 32'(adapt_en), 0);
    check("frz_mu", 32'(mu_out), 31);
    check("frz_conv", 32'(converged), 1);
    repeat (9) tick();
    freeze = 1'b0; tick();
    check("unfrz_state", 32'(state_o), 3);
    check("unfrz_mu", 32'(mu_out), 9);
    check("unfrz_adapt", 32'(adapt_en), 1);

    // Divergence at exactly thresh<<2 drops back to ACQUIRE
    drive_window(400, 400);
    pop_avg("avg_400");
    check("div_state", 32'(state_o), 2);
    check("div_conv", 32'(converged), 0);
    check("div_mu", 32'(mu_out), 5);

    // Most-negative error saturates rather than wrapping
    drive_window(-(1 << 30), -(1 << 30));
    pop_avg("avg_sat");
    check("sat_state", 32'(state_o), 2);

    // Stop mid-flush forces a full re-flush
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_state", 32'(state_o), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_mu", 32'(mu_out), 31);
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1; repeat (7) tick(); sample_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop2_state", 32'(state_o), 0);
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1; repeat (15) tick(); sample_valid = 1'b0;
    tick();
    check("reflush_15", 32'(state_o), 1);
    sample_valid = 1'b1; tick(); sample_valid = 1'b0;
    check("reflush_16", 32'(state_o), 2);

    // Back to TRACK, then reset returns everything to reset values
    for (int w = 0; w < 3; w++) begin
      drive_window(-50, 50);
      pop_avg("avg_pm50b");
    end
    check("trk2_state", 32'(state_o), 3);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("rst_trk");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
